// File: rtl/rx_timer_pkg.sv
// Shared defaults for the receive bit timer: bit-period geometry, counter widths
// and the byte size used to derive byte_received.
package rx_timer_pkg;

    localparam int DEF_CLKS_PER_BIT = 8;
    localparam int DEF_SAMPLE_PHASE = 3;
    localparam int DEF_BIT_CNT_W    = 7;
    localparam int DEF_IDLE_BITS    = 7;
    localparam int BYTE_BITS        = 8;

    // Bits needed to index a position inside one byte.
    function automatic int byte_idx_w();
        return $clog2(BYTE_BITS);
    endfunction

endpackage

// File: rtl/flex_counter.sv
// Generic up-counter with synchronous clear and programmable rollover; after
// reaching rollover_val the next enabled count returns to zero.
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out
);

    logic [NUM_CNT_BITS-1:0] count_next;

    always_comb begin
        count_next = count_out;
        if (clear) begin
            count_next = '0;
        end else if (count_enable) begin
            count_next = (count_out == rollover_val) ? '0 : count_out + NUM_CNT_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_out <= '0;
        end else begin
            count_out <= count_next;
        end
    end

endmodule

// File: rtl/rx_bit_timer.sv
// Receive bit timer: recovers the bit-sample strobe from line edges, counts
// unstuffed bits into bytes and fields, and flags missing line transitions.
module rx_bit_timer
    import rx_timer_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int SAMPLE_PHASE = DEF_SAMPLE_PHASE,
    parameter int BIT_CNT_W    = DEF_BIT_CNT_W,
    parameter int IDLE_BITS    = DEF_IDLE_BITS
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 d_edge,
    input  logic                 rcving,
    input  logic                 shift_stop,
    input  logic [BIT_CNT_W-1:0] field_len,
    output logic                 shift_enable,
    output logic                 byte_received,
    output logic                 field_received,
    output logic [BIT_CNT_W-1:0] bit_count,
    output logic                 no_edge_err
);

    localparam int PH_W   = $clog2(CLKS_PER_BIT) + 1;
    localparam int IDLE_W = $clog2(IDLE_BITS + 1);
    localparam int BIDX_W = byte_idx_w();

    logic [PH_W-1:0]   phase;
    logic [IDLE_W-1:0] idle_cnt;
    logic              counted_bit;
    logic              idle_hit;

    // A line edge resynchronises the bit period; dropping rcving parks it at zero.
    flex_counter #(
        .NUM_CNT_BITS(PH_W)
    ) u_phase (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (d_edge | ~rcving),
        .count_enable (rcving),
        .rollover_val (PH_W'(CLKS_PER_BIT - 1)),
        .count_out    (phase)
    );

    assign shift_enable   = rcving & (phase == PH_W'(SAMPLE_PHASE));
    assign counted_bit    = shift_enable & ~shift_stop;
    assign byte_received  = counted_bit & (bit_count[BIDX_W-1:0] == BIDX_W'(BYTE_BITS - 1));
    assign field_received = counted_bit & (field_len != '0)
                          & (bit_count == field_len - BIT_CNT_W'(1));
    assign idle_hit       = shift_enable & ~d_edge & (idle_cnt == IDLE_W'(IDLE_BITS - 1));
    assign no_edge_err    = idle_hit;

    // Stuffed samples still age the idle counter but never touch the bit count.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bit_count <= '0;
            idle_cnt  <= '0;
        end else if (!rcving) begin
            bit_count <= '0;
            idle_cnt  <= '0;
        end else begin
            if (field_received) begin
                bit_count <= '0;
            end else if (counted_bit) begin
                bit_count <= bit_count + BIT_CNT_W'(1);
            end

            if (d_edge || idle_hit) begin
                idle_cnt <= '0;
            end else if (shift_enable) begin
                idle_cnt <= idle_cnt + IDLE_W'(1);
            end
        end
    end

endmodule
